// File: rtl/crc_job_arbiter.sv
// crc_job_arbiter: round-robin sharing of one CRC engine between NUM_REQ requesters
module crc_job_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ),
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 eng_start,
   output logic [7:0]           eng_data,
   input  logic [11:0]          eng_result,
   input  logic                 eng_done,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [11:0]          out_data,
   output logic [ID_W-1:0]      out_id,
   output logic                 out_err,
   output logic                 busy,
   output logic [7:0]           err_count
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] OUT   = 2'd3;
   logic [1:0]      state;
   logic [ID_W-1:0] ptr, grant, idx;
   logic [TW-1:0]   timer;
   logic            any_req;
   assign any_req   = |req_valid;
   assign eng_start = state == START;
   assign out_valid = state == OUT;
   assign busy      = state != IDLE;
   // first valid requester after the last winner, scanning upward with wrap
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = ID_W'((int'(ptr) + i) % NUM_REQ);
         if (req_valid[idx]) grant = idx;
      end
   end
   // accept strobe exists only while idle so at most one job is in flight
   always_comb req_ready = (state == IDLE && any_req) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << grant : '0;
   // job sequencing: capture, start the engine, wait with watchdog, hold result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= ID_W'(NUM_REQ - 1);
         eng_data  <= '0;
         out_data  <= '0;
         out_id    <= '0;
         out_err   <= 1'b0;
         err_count <= '0;
         timer     <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               eng_data <= req_data[8*grant +: 8];
               out_id   <= grant;
               ptr      <= grant;
               state    <= START;
            end
            START: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               timer <= timer + 1'b1;
               if (eng_done) begin
                  out_data <= eng_result;
                  out_err  <= 1'b0;
                  state    <= OUT;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  out_data  <= '0;
                  out_err   <= 1'b1;
                  err_count <= (err_count == 8'hFF) ? err_count : err_count + 1'b1;
                  state     <= OUT;
               end
            end
            default: if (out_ready) state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_crc_job_arbiter.sv
// tb_crc_job_arbiter: directed vectors and corner sequences for crc_job_arbiter
module tb_crc_job_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = 32'h443322CC;
   logic [3:0]  req_ready;
   logic        eng_start;
   logic [7:0]  eng_data;
   logic [11:0] eng_result;
   logic        eng_done;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [11:0] out_data;
   logic [1:0]  out_id;
   logic        out_err;
   logic        busy;
   logic [7:0]  err_count;
   int          checks = 0;
   int          errors = 0;
   int          dly = 3;
   int          cnt;
   int          lat;

   typedef struct {
      logic [3:0]  rv;
      int          id;
      logic [11:0] cw;
   } vec_t;
   vec_t tbl[11];

   crc_job_arbiter #(.NUM_REQ(4), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .eng_start(eng_start), .eng_data(eng_data),
      .eng_result(eng_result), .eng_done(eng_done), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
      .out_err(out_err), .busy(busy), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // engine model: codeword {data,A}, done dly cycles after start, never when dly==0
   always @(posedge clk or negedge rst) begin
      if (!rst) cnt <= 0;
      else if (eng_start) cnt <= dly;
      else if (cnt > 0) cnt <= cnt - 1;
   end
   assign eng_done   = cnt == 1;
   assign eng_result = {eng_data, 4'hA};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_job(input logic [3:0] rv, input int eid, input logic [7:0] eb);
      int n = 0;
      @(negedge clk);
      req_valid = rv;
      #1;
      while (req_ready == 4'd0 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("grant", 32'(req_ready), 1 << eid);
      @(negedge clk);
      req_valid = '0;
      chk("eng_start", 32'(eng_start), 1);
      chk("eng_data", 32'(eng_data), 32'(eb));
      chk("busy_start", 32'(busy), 1);
   endtask

   task automatic finish_job(input int eid, input logic [11:0] ecw, input logic eerr, output int l);
      l = 0;
      do begin
         @(negedge clk);
         l++;
      end while (!out_valid && l < 200);
      chk("out_valid_wait", 32'(out_valid), 1);
      chk("out_id", 32'(out_id), eid);
      chk("out_data", 32'(out_data), 32'(ecw));
      chk("out_err", 32'(out_err), 32'(eerr));
      @(negedge clk);
      chk("busy_after", 32'(busy), 0);
   endtask

   initial begin
      tbl[0]  = '{4'b1111, 0, 12'h11A};
      tbl[1]  = '{4'b1111, 1, 12'h22A};
      tbl[2]  = '{4'b1111, 2, 12'h33A};
      tbl[3]  = '{4'b1111, 3, 12'h44A};
      tbl[4]  = '{4'b1111, 0, 12'h11A};
      tbl[5]  = '{4'b1010, 1, 12'h22A};
      tbl[6]  = '{4'b1010, 3, 12'h44A};
      tbl[7]  = '{4'b0110, 1, 12'h22A};
      tbl[8]  = '{4'b1001, 3, 12'h44A};
      tbl[9]  = '{4'b0001, 0, 12'h11A};
      tbl[10] = '{4'b1000, 3, 12'h44A};
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_eng_start", 32'(eng_start), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_eng_data", 32'(eng_data), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_id", 32'(out_id), 0);
      chk("rst_out_err", 32'(out_err), 0);
      chk("rst_err_count", 32'(err_count), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_no_req", 32'(req_ready), 0);
      start_job(4'b0001, 0, 8'hCC);
      finish_job(0, 12'hCCA, 1'b0, lat);
      chk("single_latency", lat, 4);
      req_data = 32'h44332211;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 11; i++) begin
         start_job(tbl[i].rv, tbl[i].id, tbl[i].cw[11:4]);
         finish_job(tbl[i].id, tbl[i].cw, 1'b0, lat);
      end
      out_ready = 1'b0;
      @(negedge clk);
      req_valid = 4'b0011;
      #1;
      chk("bp_grant", 32'(req_ready), 32'h1);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 200);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_data", 32'(out_data), 32'h11A);
         chk("bp_id", 32'(out_id), 0);
         chk("bp_req_ready", 32'(req_ready), 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_next_grant", 32'(req_ready), 32'h2);
      @(negedge clk);
      req_valid = '0;
      chk("bp_next_data", 32'(eng_data), 32'h22);
      finish_job(1, 12'h22A, 1'b0, lat);
      req_data = 32'h44332255;
      dly = 0;
      start_job(4'b0001, 0, 8'h55);
      finish_job(0, 12'h000, 1'b1, lat);
      chk("timeout_latency", lat, 65);
      chk("timeout_err_count", 32'(err_count), 1);
      dly = 3;
      start_job(4'b0001, 0, 8'h55);
      finish_job(0, 12'h55A, 1'b0, lat);
      chk("after_timeout_latency", lat, 4);
      dly = 64;
      start_job(4'b0001, 0, 8'h55);
      finish_job(0, 12'h55A, 1'b0, lat);
      chk("simul_latency", lat, 65);
      chk("simul_err_count", 32'(err_count), 1);
      req_data = 32'h44332211;
      dly = 0;
      start_job(4'b0100, 2, 8'h33);
      repeat (5) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 1);
      chk("pre_rst_id", 32'(out_id), 2);
      #2;
      rst = 1'b0;
      #1;
      chk("async_busy", 32'(busy), 0);
      chk("async_eng_data", 32'(eng_data), 0);
      chk("async_out_id", 32'(out_id), 0);
      chk("async_err_count", 32'(err_count), 0);
      chk("async_out_valid", 32'(out_valid), 0);
      chk("async_eng_start", 32'(eng_start), 0);
      @(negedge clk);
      rst = 1'b1;
      dly = 3;
      start_job(4'b1111, 0, 8'h11);
      finish_job(0, 12'h11A, 1'b0, lat);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/crc_job_arbiter.md
Name: crc_job_arbiter

Overview:
- Shares one crc_generator engine (8-bit data in, 12-bit codeword out, done flag) between NUM_REQ requesters.
- Round-robin arbitration picks one requester; its byte is captured and sequenced through the engine with a start pulse and a done-timeout watchdog.
- The codeword, tagged with the requester id, is returned on a valid/ready output port.
- Sits between the framing front-ends and the single CRC engine instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester id.
- TIMEOUT, 64, cycles allowed in WAIT for eng_done before the job aborts (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_data  in  8*NUM_REQ  requester i byte at [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_data  out  8  byte to the engine, held stable from START until the job leaves WAIT.
- eng_result  in  12  engine codeword.
- eng_done  in  1  engine completion flag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  12  codeword (0 on error).
- out_id  out  ID_W  requester index of the result.
- out_err  out  1  job aborted by timeout.
- busy  out  1  high in every state except IDLE.
- err_count  out  8  saturating timeout counter.

Behaviour:
- Reset: asserting rst=0 resets immediately, independent of clk. State=IDLE; req_ready, eng_start, out_valid, out_err and busy=0; eng_data, out_data, out_id, err_count and the timer=0; priority pointer=NUM_REQ-1, so req 0 has first priority.
- FSM states: IDLE, START, WAIT, OUT.
- IDLE, grant selection: if any req_valid, grant = first set bit searching from pointer+1 upward, with wrap.
- IDLE, accept: req_ready = onehot(grant), combinational, only in IDLE. On that edge:
  - latch req_data[grant] into eng_data and grant into out_id;
  - pointer <= grant;
  - go to START.
- IDLE, no request: with no req_valid, stay in IDLE and keep req_ready=0.
- START: eng_start=1 for exactly one cycle; timer<=0; go to WAIT.
- WAIT, timer: increments each cycle.
- WAIT, completion: on eng_done=1, out_data<=eng_result, out_err<=0, go to OUT.
- WAIT, timeout: else if timer==TIMEOUT-1, out_data<=0, out_err<=1, err_count increments (saturates at 255), go to OUT.
- WAIT, done and timeout in the same cycle: eng_done wins (no error).
- OUT: out_valid=1. out_data, out_id and out_err stay stable until out_ready=1. On out_valid&out_ready, go to IDLE next cycle.
- Latency: accept edge -> eng_start after 1 cycle. eng_done cycle -> out_valid the next cycle.
- No new request is accepted until the result has been consumed (one job in flight).
- eng_done outside WAIT is ignored.
- req_valid may drop before it is accepted; there is no pending memory.
- A requester need not hold req_data after its accept cycle.
- busy=1 in START, WAIT and OUT.

Test Plan:
- Engine model: result={data,4'hA}, done 3 cycles after eng_start.
- Single job: rst low 2 cycles, then req_valid=4'b0001, req_data[7:0]=8'hCC, out_ready=1 -> req_ready=4'b0001 for one cycle; eng_start one cycle later with eng_data=8'hCC; out_valid with out_data=12'hCCA, out_id=0, out_err=0; busy low the cycle after the handshake.
- Round-robin: all four requesters valid with bytes 8'h11,8'h22,8'h33,8'h44 held -> outputs in id order 0,1,2,3 then 0 again; codewords 12'h11A, 12'h22A, 12'h33A, 12'h44A.
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> out_data/out_id stable; req_ready stays 0 for all requesters; the next job starts only after out_ready=1.
- Timeout: model never asserts done, TIMEOUT=64 -> out_valid with out_err=1, out_data=12'h000 exactly TIMEOUT cycles after the WAIT entry cycle; err_count=1; next job proceeds normally.
- Simultaneous and reset: done on exactly the last timer cycle -> out_err=0, correct codeword. Separately, rst pulled low mid-WAIT -> all outputs 0 immediately, without waiting for a clock edge; after release, req 0 has priority again.
